instruction_sequencer: RTL and testbench
========================================

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 Clock  in  1  single clock; all state updates on posedge Clock.
REQ-002 Reset  in  1  synchronous, active-high; sampled on posedge Clock.
REQ-003 IROut  in  16  instruction register contents; [15:10] opcode, [9] WF, [8:6] DSTREG, [5:3] SREG1, [2:0] SREG2; [9:8] RSEL and [7:0] IMM for MOVI.
REQ-004 Flags  in  4  ALU flags {Z,C,N,O}.
REQ-005 Halted  out  1  high while in HALT.
REQ-006 RF_OutASel, RF_OutBSel  out  3 each  RF read-port selects.
REQ-007 RF_FunSel  out  3  RF function; RF_RegSel  out  4  RF write enables, bit3=R1 .. bit0=R4, active-high.
REQ-008 ALU_FunSel  out  5  ALU operation; ALU_WF  out  1  flag write enable.
REQ-009 ARF_FunSel  out  2  ARF function; ARF_RegSel  out  3  bit2=PC, bit1=SP, bit0=AR, active-high.
REQ-010 ARF_OutCSel, ARF_OutDSel  out  2 each  ARF read-port selects.
REQ-011 IR_Write, IR_LH  out  1 each  IR load enable and half select (0=low byte).
REQ-012 Mem_CS, Mem_WR  out  1 each  memory chip select (active-low), write (1) / read (0).
REQ-013 MuxASel, MuxBSel, MuxCSel  out  2 each; MuxDSel  out  1; DR_E  out  1; DR_FunSel  out  2; RF_ScrSel  out  4.

Function
REQ-014 FSM states: FETCH_L, FETCH_H, DECODE, EX1, EX2, HALT; all outputs are registered-free decodes of state plus the captured opcode.
REQ-015 Idle values (all states unless overridden): RegSel/ScrSel/DR_E/IR_Write/ALU_WF = 0, Mem_CS=1, Mem_WR=0, FunSel=HOLD, all mux selects 0, OutDSel=PC.
REQ-016 FETCH_L: Mem_CS=0, IR_Write=1, IR_LH=0, ARF_RegSel=3'b100 with ARF_FunSel=INC; next FETCH_H.
REQ-017 FETCH_H: as FETCH_L but IR_LH=1; next DECODE; PC advances by exactly 2 per fetch.
REQ-018 DECODE captures IROut[15:10] into an internal opcode register and drives the first execute-cycle controls.
REQ-019 BRA (0x00): DECODE drives MuxBSel=2'b11; EX1 asserts ARF_RegSel=3'b100, ARF_FunSel=LOAD, MuxBSel held; next FETCH_L.
REQ-020 BNE (0x01) / BEQ (0x02): behave as BRA when Flags[3] is 0 / 1 at DECODE; otherwise return to FETCH_L from DECODE.
REQ-021 ADD/SUB/AND/ORR (0x03-0x06): DECODE..EX2 hold OutASel=SREG1, OutBSel=SREG2, MuxDSel=0, MuxASel=2'b00, ALU_FunSel per package code; EX2 asserts RF load of DSTREG and ALU_WF=IR[9]; next FETCH_L. Three-cycle hold covers the registered MuxD and MuxA.
REQ-022 MOVI (0x07): DECODE and EX1 hold MuxASel=2'b11; EX1 loads R(RSEL+1), one-hot; next FETCH_L.
REQ-023 DSTREG/SREG codes 3'b100-3'b111 map to R1-R4; any other code makes the instruction a NOP with no register write.
REQ-024 HLT (0x08): enter HALT, Halted=1, idle outputs, remain until Reset.
REQ-025 Undefined opcodes: NOP, DECODE -> FETCH_L.
REQ-026 Exactly one register-file write enable (RF or ARF) per cycle; never both.

Reset
REQ-027 Reset=1 forces state FETCH_L, opcode register 0, Halted=0, idle outputs next cycle; overrides any state including HALT and mid-execute (no write issued that cycle).
REQ-028 First fetch begins the cycle after Reset deasserts.

Structure
REQ-029 Shared package holds the state enum, opcode constants, and FunSel codes (HOLD, LOAD, INC, DEC for RF/ARF; ALU ADD/SUB/AND/ORR).
REQ-030 Single module; no sub-module required.

Verification
REQ-031 Reset then IROut=16'h1C81 (MOVI R1, 0x81): FETCH_L/FETCH_H with PC INC; EX1 RF_RegSel=4'b1000, MuxASel=2'b11.
REQ-032 ADD R2<-R1+R3, WF=1: RegSel stays 0 until EX2, then 4'b0100 with ALU_WF=1 for exactly one cycle.
REQ-033 BNE with Flags=4'b1000: DECODE -> FETCH_L, no ARF load; with Flags=4'b0000: EX1 ARF_RegSel=3'b100, ARF_FunSel=LOAD.
REQ-034 HLT: Halted=1 and outputs idle for 20 cycles; Reset pulse -> FETCH_L, Halted=0.
REQ-035 Reset asserted during EX1 of ADD: no RF write; next cycle FETCH_L.
REQ-036 Opcode 0x3F or DSTREG=3'b010: no RF/ARF write; return to FETCH_L.

Source files
------------

// File: rtl/instruction_sequencer_pkg.sv
// Shared encodings for the instruction sequencer: FSM states, opcodes,
// function-select codes and small field-decode helpers.
package instruction_sequencer_pkg;

    typedef enum logic [2:0] {
        S_FETCH_L = 3'd0,
        S_FETCH_H = 3'd1,
        S_DECODE  = 3'd2,
        S_EX1     = 3'd3,
        S_EX2     = 3'd4,
        S_HALT    = 3'd5
    } state_e;

    localparam logic [5:0] OP_BRA  = 6'h00;
    localparam logic [5:0] OP_BNE  = 6'h01;
    localparam logic [5:0] OP_BEQ  = 6'h02;
    localparam logic [5:0] OP_ADD  = 6'h03;
    localparam logic [5:0] OP_SUB  = 6'h04;
    localparam logic [5:0] OP_AND  = 6'h05;
    localparam logic [5:0] OP_ORR  = 6'h06;
    localparam logic [5:0] OP_MOVI = 6'h07;
    localparam logic [5:0] OP_HLT  = 6'h08;

    localparam logic [2:0] RF_HOLD  = 3'd0;
    localparam logic [2:0] RF_LOAD  = 3'd1;
    localparam logic [2:0] RF_INC   = 3'd2;
    localparam logic [2:0] RF_DEC   = 3'd3;

    localparam logic [1:0] ARF_HOLD = 2'd0;
    localparam logic [1:0] ARF_LOAD = 2'd1;
    localparam logic [1:0] ARF_INC  = 2'd2;
    localparam logic [1:0] ARF_DEC  = 2'd3;

    localparam logic [1:0] DR_HOLD  = 2'd0;

    localparam logic [4:0] ALU_NONE = 5'h00;
    localparam logic [4:0] ALU_ADD  = 5'h14;
    localparam logic [4:0] ALU_SUB  = 5'h16;
    localparam logic [4:0] ALU_AND  = 5'h17;
    localparam logic [4:0] ALU_ORR  = 5'h18;

    localparam logic [1:0] ARF_SEL_PC = 2'd0;
    localparam logic [1:0] MUXA_ALU   = 2'b00;
    localparam logic [1:0] MUXA_IMM   = 2'b11;
    localparam logic [1:0] MUXB_IR    = 2'b11;
    localparam logic [2:0] ARF_PC_EN  = 3'b100;

    function automatic logic is_alu(input logic [5:0] op);
        return (op >= OP_ADD) && (op <= OP_ORR);
    endfunction

    function automatic logic [4:0] alu_fun(input logic [5:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_ORR:  return ALU_ORR;
            default: return ALU_NONE;
        endcase
    endfunction

    // Only codes 3'b100..3'b111 name real registers (R1..R4)
    function automatic logic reg_ok(input logic [2:0] code);
        return code[2];
    endfunction

    function automatic logic [3:0] reg_onehot(input logic [1:0] idx);
        return 4'b1000 >> idx;
    endfunction

endpackage

// File: rtl/instruction_sequencer.sv
// Multi-cycle control sequencer: two-byte fetch, decode, up to two execute
// cycles; all control outputs are combinational decodes of state and opcode.
module instruction_sequencer
    import instruction_sequencer_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  Flags,
    output logic        Halted,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [2:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [4:0]  ALU_FunSel,
    output logic        ALU_WF,
    output logic [1:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic        IR_Write,
    output logic        IR_LH,
    output logic        Mem_CS,
    output logic        Mem_WR,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic [1:0]  MuxCSel,
    output logic        MuxDSel,
    output logic        DR_E,
    output logic [1:0]  DR_FunSel,
    output logic [3:0]  RF_ScrSel
);

    state_e      state_q, state_d;
    logic [5:0]  opcode_q, opcode_d;
    logic [5:0]  op_now;
    logic        alu_ok, taken, alu_hold;
    logic        unused_flags;

    assign unused_flags = ^Flags[2:0];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= S_FETCH_L;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    // In DECODE the opcode register is not loaded yet, so look at IR directly
    assign op_now = (state_q == S_DECODE) ? IROut[15:10] : opcode_q;
    assign alu_ok = reg_ok(IROut[8:6]) & reg_ok(IROut[5:3]) & reg_ok(IROut[2:0]);
    assign taken  = (op_now == OP_BRA) ||
                    (op_now == OP_BNE && !Flags[3]) ||
                    (op_now == OP_BEQ &&  Flags[3]);

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        alu_hold    = 1'b0;
        Halted      = 1'b0;
        RF_OutASel  = '0;
        RF_OutBSel  = '0;
        RF_FunSel   = RF_HOLD;
        RF_RegSel   = '0;
        ALU_FunSel  = ALU_NONE;
        ALU_WF      = 1'b0;
        ARF_FunSel  = ARF_HOLD;
        ARF_RegSel  = '0;
        ARF_OutCSel = '0;
        ARF_OutDSel = ARF_SEL_PC;
        IR_Write    = 1'b0;
        IR_LH       = 1'b0;
        Mem_CS      = 1'b1;
        Mem_WR      = 1'b0;
        MuxASel     = '0;
        MuxBSel     = '0;
        MuxCSel     = '0;
        MuxDSel     = 1'b0;
        DR_E        = 1'b0;
        DR_FunSel   = DR_HOLD;
        RF_ScrSel   = '0;

        // Reset holds every output idle so a mid-execute write is squashed
        if (!Reset) begin
            case (state_q)
                S_FETCH_L, S_FETCH_H: begin
                    Mem_CS     = 1'b0;
                    IR_Write   = 1'b1;
                    IR_LH      = (state_q == S_FETCH_H);
                    ARF_RegSel = ARF_PC_EN;
                    ARF_FunSel = ARF_INC;
                    state_d    = (state_q == S_FETCH_L) ? S_FETCH_H : S_DECODE;
                end
                S_DECODE: begin
                    opcode_d = IROut[15:10];
                    state_d  = S_FETCH_L;
                    if (taken) begin
                        MuxBSel = MUXB_IR;
                        state_d = S_EX1;
                    end else if (is_alu(op_now) && alu_ok) begin
                        alu_hold = 1'b1;
                        state_d  = S_EX1;
                    end else if (op_now == OP_MOVI) begin
                        MuxASel = MUXA_IMM;
                        state_d = S_EX1;
                    end else if (op_now == OP_HLT) begin
                        state_d = S_HALT;
                    end
                end
                S_EX1: begin
                    state_d = S_FETCH_L;
                    if (is_alu(op_now)) begin
                        alu_hold = 1'b1;
                        state_d  = S_EX2;
                    end else if (op_now == OP_MOVI) begin
                        MuxASel   = MUXA_IMM;
                        RF_FunSel = RF_LOAD;
                        RF_RegSel = reg_onehot(IROut[9:8]);
                    end else if (op_now <= OP_BEQ) begin
                        MuxBSel    = MUXB_IR;
                        ARF_RegSel = ARF_PC_EN;
                        ARF_FunSel = ARF_LOAD;
                    end
                end
                S_EX2: begin
                    alu_hold  = 1'b1;
                    RF_FunSel = RF_LOAD;
                    RF_RegSel = reg_onehot(IROut[7:6]);
                    ALU_WF    = IROut[9];
                    state_d   = S_FETCH_L;
                end
                S_HALT: begin
                    Halted  = 1'b1;
                    state_d = S_HALT;
                end
                default: state_d = S_FETCH_L;
            endcase

            // ALU operand routing stays up DECODE..EX2 to cover the MuxD/MuxA pipeline
            if (alu_hold) begin
                RF_OutASel = IROut[5:3];
                RF_OutBSel = IROut[2:0];
                MuxDSel    = 1'b0;
                MuxASel    = MUXA_ALU;
                ALU_FunSel = alu_fun(op_now);
            end
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench: stimulus pushes per-cycle expected controls into a queue,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_instruction_sequencer;
    import instruction_sequencer_pkg::*;

    typedef struct packed {
        logic       halted;
        logic [3:0] rf_regsel;
        logic [2:0] rf_funsel;
        logic       alu_wf;
        logic [4:0] alu_fun;
        logic [2:0] arf_regsel;
        logic [1:0] arf_funsel;
        logic       mem_cs;
        logic       mem_wr;
        logic       ir_write;
        logic       ir_lh;
        logic [1:0] muxa;
        logic [1:0] muxb;
        logic       muxd;
        logic [2:0] outa;
        logic [2:0] outb;
        logic [1:0] outd;
    } exp_t;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] IROut = '0;
    logic [3:0]  Flags = '0;
    logic        Halted, ALU_WF, IR_Write, IR_LH, Mem_CS, Mem_WR, MuxDSel, DR_E;
    logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel, ARF_RegSel;
    logic [3:0]  RF_RegSel, RF_ScrSel;
    logic [4:0]  ALU_FunSel;
    logic [1:0]  ARF_FunSel, ARF_OutCSel, ARF_OutDSel, MuxASel, MuxBSel, MuxCSel, DR_FunSel;

    int checks = 0;
    int errors = 0;
    exp_t  exp_q[$];
    string name_q[$];

    always #5 Clock = ~Clock;

    instruction_sequencer dut (
        .Clock(Clock), .Reset(Reset), .IROut(IROut), .Flags(Flags),
        .Halted(Halted), .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel),
        .RF_FunSel(RF_FunSel), .RF_RegSel(RF_RegSel), .ALU_FunSel(ALU_FunSel),
        .ALU_WF(ALU_WF), .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
        .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel), .IR_Write(IR_Write),
        .IR_LH(IR_LH), .Mem_CS(Mem_CS), .Mem_WR(Mem_WR), .MuxASel(MuxASel),
        .MuxBSel(MuxBSel), .MuxCSel(MuxCSel), .MuxDSel(MuxDSel), .DR_E(DR_E),
        .DR_FunSel(DR_FunSel), .RF_ScrSel(RF_ScrSel)
    );

    function automatic exp_t e_idle();
        exp_t e;
        e = '0;
        e.rf_funsel  = RF_HOLD;
        e.arf_funsel = ARF_HOLD;
        e.alu_fun    = ALU_NONE;
        e.mem_cs     = 1'b1;
        e.outd       = ARF_SEL_PC;
        return e;
    endfunction

    function automatic exp_t e_fetch(input logic lh);
        exp_t e;
        e = e_idle();
        e.mem_cs     = 1'b0;
        e.ir_write   = 1'b1;
        e.ir_lh      = lh;
        e.arf_regsel = 3'b100;
        e.arf_funsel = ARF_INC;
        return e;
    endfunction

    function automatic exp_t e_alu(input logic [4:0] f, input logic [2:0] a, input logic [2:0] b);
        exp_t e;
        e = e_idle();
        e.alu_fun = f;
        e.outa    = a;
        e.outb    = b;
        return e;
    endfunction

    // Monitor: every sampled cycle is one scoreboard entry
    always @(negedge Clock) begin
        exp_t  e, act;
        string nm;
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            act = '{halted: Halted, rf_regsel: RF_RegSel, rf_funsel: RF_FunSel,
                    alu_wf: ALU_WF, alu_fun: ALU_FunSel, arf_regsel: ARF_RegSel,
                    arf_funsel: ARF_FunSel, mem_cs: Mem_CS, mem_wr: Mem_WR,
                    ir_write: IR_Write, ir_lh: IR_LH, muxa: MuxASel, muxb: MuxBSel,
                    muxd: MuxDSel, outa: RF_OutASel, outb: RF_OutBSel, outd: ARF_OutDSel};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %h required %h", nm, act, e);
            end
            checks++;
            if ((RF_RegSel != 4'b0) && (ARF_RegSel != 3'b0)) begin
                errors++;
                $display("FAIL onewrite@%s: got rf=%b arf=%b required not both", nm, RF_RegSel, ARF_RegSel);
            end
        end
    end

    task automatic cyc(input exp_t e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge Clock);
        #1;
    endtask

    task automatic fetch2(input logic [15:0] ir, input string nm);
        IROut = ir;
        cyc(e_fetch(1'b0), {nm, ".fetch_l"});
        cyc(e_fetch(1'b1), {nm, ".fetch_h"});
    endtask

    // Full ADD-class instruction: operands held DECODE..EX2, write only in EX2
    task automatic alu_instr(input logic [15:0] ir, input logic [4:0] f,
                             input logic [3:0] wsel, input string nm);
        exp_t e;
        fetch2(ir, nm);
        e = e_alu(f, ir[5:3], ir[2:0]);
        cyc(e, {nm, ".decode"});
        cyc(e, {nm, ".ex1"});
        e.rf_regsel = wsel;
        e.rf_funsel = RF_LOAD;
        e.alu_wf    = ir[9];
        cyc(e, {nm, ".ex2"});
    endtask

    task automatic branch(input logic [15:0] ir, input logic [3:0] fl,
                          input logic tk, input string nm);
        exp_t e;
        Flags = fl;
        fetch2(ir, nm);
        e = e_idle();
        if (tk) begin
            e.muxb = 2'b11;
            cyc(e, {nm, ".decode"});
            e.arf_regsel = 3'b100;
            e.arf_funsel = ARF_LOAD;
            cyc(e, {nm, ".ex1"});
        end else begin
            cyc(e, {nm, ".decode"});
        end
    endtask

    initial begin
        exp_t e;
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        cyc(e_idle(), "reset0");
        cyc(e_idle(), "reset1");
        Reset = 1'b0;

        // MOVI R1, 0x81
        fetch2(16'h1C81, "movi_r1");
        e = e_idle(); e.muxa = 2'b11;
        cyc(e, "movi_r1.decode");
        e.rf_regsel = 4'b1000; e.rf_funsel = RF_LOAD;
        cyc(e, "movi_r1.ex1");

        // MOVI R3 (RSEL=2), 0x55
        fetch2(16'h1E55, "movi_r3");
        e = e_idle(); e.muxa = 2'b11;
        cyc(e, "movi_r3.decode");
        e.rf_regsel = 4'b0010; e.rf_funsel = RF_LOAD;
        cyc(e, "movi_r3.ex1");

        // ADD R2 <- R1 + R3, WF=1 ; SUB R4 <- R2 - R1, WF=0
        alu_instr(16'h0F66, ALU_ADD, 4'b0100, "add");
        alu_instr(16'h11EC, ALU_SUB, 4'b0001, "sub");

        branch(16'h0400, 4'b1000, 1'b0, "bne_nt");
        branch(16'h0400, 4'b0000, 1'b1, "bne_t");
        branch(16'h0800, 4'b1000, 1'b1, "beq_t");
        branch(16'h0800, 4'b0000, 1'b0, "beq_nt");
        branch(16'h0000, 4'b1000, 1'b1, "bra");
        Flags = 4'b0000;

        // Undefined opcode and ADD with illegal DSTREG are NOPs
        fetch2(16'hFC00, "op3f");
        cyc(e_idle(), "op3f.decode");
        fetch2(16'h0EA6, "bad_dst");
        cyc(e_idle(), "bad_dst.decode");

        // Reset during EX1 of ADD squashes the instruction
        fetch2(16'h0F66, "add_rst");
        e = e_alu(ALU_ADD, 3'b100, 3'b110);
        cyc(e, "add_rst.decode");
        Reset = 1'b1;
        cyc(e_idle(), "add_rst.ex1_reset");
        Reset = 1'b0;
        cyc(e_fetch(1'b0), "add_rst.refetch");
        cyc(e_fetch(1'b1), "add_rst.refetch_h");
        IROut = 16'h2000;
        cyc(e_idle(), "hlt.decode");

        // HALT holds for 20 cycles, then a reset pulse restarts fetch
        e = e_idle(); e.halted = 1'b1;
        for (int i = 0; i < 20; i++) cyc(e, "hlt.halted");
        Reset = 1'b1;
        cyc(e_idle(), "hlt.reset");
        Reset = 1'b0;
        IROut = 16'hFC00;
        cyc(e_fetch(1'b0), "hlt.restart");

        repeat (4) @(posedge Clock);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
